// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the ssdram controller port: video has strict
// priority, CPU and DMA share round-robin, one fixed-length access at a time.
module sdram_port_arbiter #(
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 8,
   parameter int ACC_CYC = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              vid_req_i,
   input  logic [ADDR_W-1:0] vid_addr_i,
   output logic [DATA_W-1:0] vid_data_o,
   output logic              vid_ack_o,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic [DATA_W-1:0] cpu_data_o,
   output logic              cpu_ack_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_data_i,
   output logic [DATA_W-1:0] dma_data_o,
   output logic              dma_ack_o,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_i,
   input  logic [DATA_W-1:0] ram_data_o,
   output logic              ram_cs_i,
   output logic              ram_oe_i,
   output logic              ram_we_i,
   output logic [1:0]        grant_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [1:0] G_VID = 2'd1, G_CPU = 2'd2, G_DMA = 2'd3;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              last_dma;
   logic              we_r;
   logic [1:0]        win;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              sel_we;

   // Only meaningful in IDLE; the CPU/DMA tie goes to whoever was not served last.
   always_comb begin
      win = 2'd0;
      if (vid_req_i)                   win = G_VID;
      else if (cpu_req_i && dma_req_i) win = last_dma ? G_CPU : G_DMA;
      else if (cpu_req_i)              win = G_CPU;
      else if (dma_req_i)              win = G_DMA;
   end

   always_comb begin
      sel_addr = vid_addr_i;
      sel_data = '0;
      sel_we   = 1'b0;
      case (win)
         G_CPU: begin sel_addr = cpu_addr_i; sel_data = cpu_data_i; sel_we = cpu_we_i; end
         G_DMA: begin sel_addr = dma_addr_i; sel_data = dma_data_i; sel_we = dma_we_i; end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win != 2'd0) state_nxt = ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         last_dma   <= 1'b1;
         we_r       <= 1'b0;
         grant_o    <= '0;
         ram_addr   <= '0;
         ram_data_i <= '0;
         ram_cs_i   <= 1'b0;
         ram_oe_i   <= 1'b0;
         ram_we_i   <= 1'b0;
         vid_ack_o  <= 1'b0;
         cpu_ack_o  <= 1'b0;
         dma_ack_o  <= 1'b0;
         vid_data_o <= '0;
         cpu_data_o <= '0;
         dma_data_o <= '0;
      end else begin
         vid_ack_o <= 1'b0;
         cpu_ack_o <= 1'b0;
         dma_ack_o <= 1'b0;
         case (state)
            IDLE: if (win != 2'd0) begin
               grant_o    <= win;
               ram_addr   <= sel_addr;
               ram_data_i <= sel_data;
               we_r       <= sel_we;
               ram_cs_i   <= 1'b1;
               ram_oe_i   <= ~sel_we;
               ram_we_i   <= sel_we;
               cnt        <= 4'(ACC_CYC - 1);
            end
            ACCESS: if (cnt == 4'd0) begin
               ram_cs_i <= 1'b0;
               ram_oe_i <= 1'b0;
               ram_we_i <= 1'b0;
               // Read data is guaranteed valid only in the last strobe cycle.
               case (grant_o)
                  G_VID: begin vid_ack_o <= 1'b1; vid_data_o <= ram_data_o; end
                  G_CPU: begin cpu_ack_o <= 1'b1; if (!we_r) cpu_data_o <= ram_data_o; end
                  G_DMA: begin dma_ack_o <= 1'b1; if (!we_r) dma_data_o <= ram_data_o; end
                  default: ;
               endcase
            end else begin
               cnt <= cnt - 4'd1;
            end
            DONE: begin
               if (grant_o[1]) last_dma <= (grant_o == G_DMA);
               grant_o <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized requesters against a transaction-schedule model of the arbiter,
// followed by directed write/read-back and reset-abort sequences.
module tb_sdram_port_arbiter;
   localparam int ADDR_W = 23, DATA_W = 8, A = 4;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              r_req [3];
   logic              r_we  [3];
   logic [ADDR_W-1:0] r_addr[3];
   logic [DATA_W-1:0] r_data[3];
   logic [DATA_W-1:0] vid_data_o, cpu_data_o, dma_data_o, ram_data_i, ram_data_o;
   logic              vid_ack_o, cpu_ack_o, dma_ack_o, ram_cs_i, ram_oe_i, ram_we_i, busy_o;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        grant_o;

   sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(A)) dut (
      .clock(clock), .reset_n(reset_n),
      .vid_req_i(r_req[0]), .vid_addr_i(r_addr[0]), .vid_data_o(vid_data_o), .vid_ack_o(vid_ack_o),
      .cpu_req_i(r_req[1]), .cpu_we_i(r_we[1]), .cpu_addr_i(r_addr[1]), .cpu_data_i(r_data[1]),
      .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack_o),
      .dma_req_i(r_req[2]), .dma_we_i(r_we[2]), .dma_addr_i(r_addr[2]), .dma_data_i(r_data[2]),
      .dma_data_o(dma_data_o), .dma_ack_o(dma_ack_o),
      .ram_addr(ram_addr), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
      .ram_cs_i(ram_cs_i), .ram_oe_i(ram_oe_i), .ram_we_i(ram_we_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_err = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // SDRAM stand-in: read data only appears once the strobes have been held ACC_CYC cycles.
   logic [DATA_W-1:0] mem[16];
   int                cs_cnt = 0;
   always @(posedge clock) begin
      cs_cnt <= ram_cs_i ? cs_cnt + 1 : 0;
      if (ram_cs_i && ram_we_i) mem[ram_addr[3:0]] <= ram_data_i;
   end
   assign ram_data_o = (ram_cs_i && ram_oe_i && cs_cnt == A - 1) ? mem[ram_addr[3:0]] : 8'hEE;

   // Reference: an access granted at cycle g strobes g+1..g+A, acks at g+A+1, frees at g+A+2.
   logic              m_act = 1'b0, m_we = 1'b0, rr_dma = 1'b1;
   int                m_free = 0, m_g = 0, m_p = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wd = '0;
   logic [DATA_W-1:0] exp_do[3];
   logic [DATA_W-1:0] ref_mem[16];
   logic [2:0]        ack_q = '0;

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      for (int i = 0; i < 3; i++) exp_do[i] = '0;
      forever begin
         logic [2:0] acks;
         logic in_acc, in_done;
         @(negedge clock);
         acks = {dma_ack_o, cpu_ack_o, vid_ack_o};
         if (!reset_n) begin
            chk("rst_outs", {ram_cs_i, ram_oe_i, ram_we_i, busy_o, grant_o, acks, ram_addr, ram_data_i}, '0);
            chk("rst_dout", {vid_data_o, cpu_data_o, dma_data_o}, '0);
            m_act = 1'b0; m_free = 0; rr_dma = 1'b1;
            for (int i = 0; i < 3; i++) exp_do[i] = '0;
         end else begin
            in_acc  = m_act && cyc > m_g && cyc <= m_g + A;
            in_done = m_act && cyc == m_g + A + 1;
            chk("cs",    ram_cs_i, in_acc);
            chk("oe",    ram_oe_i, in_acc && !m_we);
            chk("we",    ram_we_i, in_acc && m_we);
            chk("busy",  busy_o, in_acc || in_done);
            chk("grant", grant_o, (in_acc || in_done) ? m_p + 1 : 0);
            chk("ack",   acks, in_done ? (32'd1 << m_p) : 32'd0);
            if (in_acc) chk("addr", ram_addr, m_addr);
            if (in_acc && m_we) chk("wdata", ram_data_i, m_wd);
            if (in_done) begin
               if (!m_we) exp_do[m_p] = ref_mem[m_addr[3:0]];
               m_act = 1'b0;
               m_free = cyc + 1;
            end
            chk("vid_do", vid_data_o, exp_do[0]);
            chk("cpu_do", cpu_data_o, exp_do[1]);
            chk("dma_do", dma_data_o, exp_do[2]);
            if (!m_act && cyc >= m_free && (r_req[0] || r_req[1] || r_req[2])) begin
               if (r_req[0])                 m_p = 0;
               else if (r_req[1] && r_req[2]) m_p = rr_dma ? 1 : 2;
               else if (r_req[1])            m_p = 1;
               else                          m_p = 2;
               if (m_p != 0) rr_dma = (m_p == 2);
               m_act  = 1'b1;
               m_g    = cyc;
               m_addr = r_addr[m_p];
               m_we   = (m_p != 0) && r_we[m_p];
               m_wd   = r_data[m_p];
               if (m_we) ref_mem[m_addr[3:0]] = m_wd;
            end
         end
         ack_q = acks;
      end
   end

   task automatic new_tx(input int p);
      r_addr[p] = ADDR_W'($urandom);
      r_data[p] = DATA_W'($urandom);
      r_we[p]   = (p != 0) && ($urandom_range(0, 1) == 1);
   endtask

   task automatic do_acc(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] q);
      logic got = 1'b0;
      r_req[p] = 1'b1; r_we[p] = we; r_addr[p] = a; r_data[p] = d;
      for (int i = 0; i < 30 && !got; i++) begin
         @(posedge clock); #1;
         got = ack_q[p];
      end
      chk("acc_ack", got, 1'b1);
      q = (p == 0) ? vid_data_o : (p == 1) ? cpu_data_o : dma_data_o;
      r_req[p] = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] q;
      logic stop, got;
      for (int p = 0; p < 3; p++) begin
         r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_data[p] = '0;
      end
      #1 reset_n = 1'b0;
      #1;
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_strb", {ram_cs_i, ram_oe_i, ram_we_i, grant_o}, '0);
      #21 reset_n = 1'b1;

      stop = 1'b0;
      for (int c = 0; c < 1700; c++) begin
         @(posedge clock); #1;
         if (c == 1500) stop = 1'b1;
         for (int p = 0; p < 3; p++) begin
            if (r_req[p] && ack_q[p]) begin
               r_req[p] = !stop && ($urandom_range(0, 1) == 1);
               if (r_req[p]) new_tx(p);
            end else if (r_req[p]) begin
               if (p != 0 && $urandom_range(0, 3) == 0) new_tx(p);
            end else if (!stop && $urandom_range(0, (p == 0) ? 7 : 2) == 0) begin
               r_req[p] = 1'b1;
               new_tx(p);
            end
         end
      end
      chk("drained", {r_req[0], r_req[1], r_req[2], busy_o}, '0);

      do_acc(2, 1'b1, 23'h7FFFF, 8'h3C, q);
      do_acc(2, 1'b0, 23'h7FFFF, 8'h00, q);
      chk("dma_rdback", q, 8'h3C);
      do_acc(2, 1'b1, 23'h00123, 8'hA5, q);
      do_acc(1, 1'b0, 23'h00123, 8'h00, q);
      chk("cpu_rd", q, 8'hA5);

      // Abort a CPU read in its second strobe cycle; it must rerun after release.
      @(posedge clock); #1;
      r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 23'h00123;
      @(posedge clock);
      @(posedge clock); #2;
      reset_n = 1'b0;
      #1;
      chk("abort_cs",   ram_cs_i, 1'b0);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_ack",  cpu_ack_o, 1'b0);
      chk("abort_do",   cpu_data_o, 8'h00);
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clock); #1;
         got = ack_q[1];
      end
      chk("rerun_ack", got, 1'b1);
      chk("rerun_do", cpu_data_o, 8'hA5);
      r_req[1] = 1'b0;
      repeat (3) @(posedge clock);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
